host_port_arbiter: RTL

// - Shares one host memory channel pair (byte read, byte write) between NUM_REQ accelerator wrappers.
// - Each wrapper runs its own HLS core and byte buffer; this block sits between those wrappers and the host port.
// - Read and write channels are arbitrated independently, each round-robin.
// - A grant is held for a whole burst, i.e. until the granted requester drops its enable.

---
 rtl/host_port_arbiter.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/host_port_arbiter.sv
// rtl/host_port_arbiter.sv - round-robin sharing of one host read/write byte port pair among NUM_REQ wrappers
// Optional watchdog: define HPA_WATCHDOG_EN to enable grant revocation after TIMEOUT_CYC idle cycles.

// Single-channel burst arbiter: round-robin winner selection, grant held until the owner drops enable.
module hpa_channel_arb #(
  parameter int NUM_REQ = 4
`ifdef HPA_WATCHDOG_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] enable,
`ifdef HPA_WATCHDOG_EN
  input  logic               beat,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic               timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IW-1:0]      idx_q;
  logic [IW-1:0]      ptr_q;
  logic [NUM_REQ-1:0] eligible;
  logic [IW:0]        cand;
  logic [IW-1:0]      win_idx;
  logic               win_found;
  logic [IW-1:0]      next_ptr;

`ifdef HPA_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0]      cnt_q;
  logic [NUM_REQ-1:0] blocked_q;
  logic               timeout_q;
  assign eligible = enable & ~blocked_q;
  assign timeout  = timeout_q;
`else
  assign eligible = enable;
  assign timeout  = 1'b0;
`endif

  assign grant    = grant_q;
  assign next_ptr = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  // Pick the first eligible requester at or after the round-robin pointer, wrapping modulo NUM_REQ.
  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!win_found && eligible[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  // Channel FSM: IDLE grants a winner, BUSY holds it until the owner releases (or the watchdog revokes).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
`ifdef HPA_WATCHDOG_EN
      cnt_q     <= '0;
      blocked_q <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef HPA_WATCHDOG_EN
      // A revoked requester stays ignored until it lets go of its enable.
      blocked_q <= blocked_q & enable;
`endif
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_q <= S_BUSY;
            grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
            idx_q   <= win_idx;
`ifdef HPA_WATCHDOG_EN
            cnt_q   <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (!enable[idx_q]) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= next_ptr;
          end
`ifdef HPA_WATCHDOG_EN
          else if (!beat && (cnt_q == CW'(TIMEOUT_CYC - 1))) begin
            state_q          <= S_IDLE;
            grant_q          <= '0;
            ptr_q            <= next_ptr;
            timeout_q        <= 1'b1;
            blocked_q[idx_q] <= 1'b1;
          end else if (beat) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// Top: independent read and write arbiters plus the host-side muxing and ready routing.
module host_port_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WID    = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_read_enable,
  input  logic [64*NUM_REQ-1:0]       req_read_addr,
  input  logic [64*NUM_REQ-1:0]       req_read_size,
  input  logic [NUM_REQ-1:0]          req_finish_read,
  output logic [NUM_REQ-1:0]          req_read_ready,
  output logic [DATA_WID-1:0]         req_read_data,
  input  logic [NUM_REQ-1:0]          req_write_enable,
  input  logic [64*NUM_REQ-1:0]       req_write_addr,
  input  logic [64*NUM_REQ-1:0]       req_write_size,
  input  logic [DATA_WID*NUM_REQ-1:0] req_write_data,
  input  logic [NUM_REQ-1:0]          req_finish_write,
  output logic [NUM_REQ-1:0]          req_write_ready,
  output logic                        host_read_enable,
  output logic [63:0]                 host_read_addr,
  output logic [63:0]                 host_read_size,
  output logic                        host_finish_read,
  input  logic [63:0]                 host_read_ready,
  input  logic [DATA_WID-1:0]         host_read_data,
  output logic                        host_write_enable,
  output logic [63:0]                 host_write_addr,
  output logic [63:0]                 host_write_size,
  output logic [DATA_WID-1:0]         host_write_data,
  output logic                        host_finish_write,
  input  logic [63:0]                 host_write_ready,
  output logic [NUM_REQ-1:0]          rd_grant,
  output logic [NUM_REQ-1:0]          wr_grant,
  output logic                        timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("host_port_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC positive");
  end

  logic rd_beat;
  logic wr_beat;
  logic rd_to;
  logic wr_to;

  // The host signals a beat only when its 64-bit ready word is exactly 1.
  assign rd_beat = (host_read_ready == 64'd1);
  assign wr_beat = (host_write_ready == 64'd1);

  hpa_channel_arb #(
    .NUM_REQ     (NUM_REQ)
`ifdef HPA_WATCHDOG_EN
    , .TIMEOUT_CYC (TIMEOUT_CYC)
`endif
  ) u_rd_arb (
    .clk     (clk),
    .reset   (reset),
    .enable  (req_read_enable),
`ifdef HPA_WATCHDOG_EN
    .beat    (rd_beat),
`endif
    .grant   (rd_grant),
    .timeout (rd_to)
  );

  hpa_channel_arb #(
    .NUM_REQ     (NUM_REQ)
`ifdef HPA_WATCHDOG_EN
    , .TIMEOUT_CYC (TIMEOUT_CYC)
`endif
  ) u_wr_arb (
    .clk     (clk),
    .reset   (reset),
    .enable  (req_write_enable),
`ifdef HPA_WATCHDOG_EN
    .beat    (wr_beat),
`endif
    .grant   (wr_grant),
    .timeout (wr_to)
  );

  assign timeout_err       = rd_to | wr_to;
  assign req_read_ready    = rd_grant & {NUM_REQ{rd_beat}};
  assign req_write_ready   = wr_grant & {NUM_REQ{wr_beat}};
  assign req_read_data     = host_read_data;
  assign host_read_enable  = |(req_read_enable & rd_grant);
  assign host_finish_read  = |(req_finish_read & rd_grant);
  assign host_write_enable = |(req_write_enable & wr_grant);
  assign host_finish_write = |(req_finish_write & wr_grant);

  // One-hot grants make an OR of masked slices a plain mux that reads zero when nobody is granted.
  always_comb begin
    host_read_addr  = '0;
    host_read_size  = '0;
    host_write_addr = '0;
    host_write_size = '0;
    host_write_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_grant[i]) begin
        host_read_addr = host_read_addr | req_read_addr[64*i +: 64];
        host_read_size = host_read_size | req_read_size[64*i +: 64];
      end
      if (wr_grant[i]) begin
        host_write_addr = host_write_addr | req_write_addr[64*i +: 64];
        host_write_size = host_write_size | req_write_size[64*i +: 64];
        host_write_data = host_write_data | req_write_data[DATA_WID*i +: DATA_WID];
      end
    end
  end

endmodule
